core_sequencer: RTL

- Parametrised multi-cycle fetch/decode/execute sequencer for the 32-bit core; successor to the free-running pc_trigger/decode scheme.
- Owns the PC and the NZCV flag register, fetches through a req/ack handshake, and decodes the fixed instruction fields.
- Evaluates the 4-bit condition code, then either issues one execute strobe to the ALU/register bank and waits for completion, or retires the instruction as a no-op.
- Adds three things the previous generation lacked: conditional skip, relative branch, and halt.

---
 rtl/core_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC and NZCV, fetches over req/ack,
// conditionally issues one ALU strobe per instruction, and supports relative branch and halt.
module core_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            pc_reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [3:0]      condition,
  output logic [3:0]      opcode,
  output logic            s_bit,
  output logic [3:0]      destination,
  output logic [3:0]      source1,
  output logic [3:0]      source2,
  output logic [15:0]     immediate_value,
  output logic [2:0]      shift_control,
  output logic            exec_valid,
  input  logic            exec_done,
  input  logic [3:0]      alu_flags,
  output logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_B    = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  // Reset word decodes as a NOP in every field, so opcode comes out of reset as 4'hF.
  localparam logic [31:0] RESET_INSTR = 32'h0F00_0000;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic [31:0]     instr_q;
  logic            cond_pass;
  logic [2:0]      retire_state;
  logic            instr_load;

  logic n_f, z_f, c_f, v_f;
  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign c_f = flags_q[1];
  assign v_f = flags_q[0];

  always_comb begin
    cond_pass = 1'b0;
    case (instr_q[31:28])
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = !z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = !c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = !n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = !v_f;
      4'h8: cond_pass = c_f && !z_f;
      4'h9: cond_pass = !c_f || z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = !z_f && (n_f == v_f);
      4'hD: cond_pass = z_f || (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign retire_state = run ? S_FETCH : S_IDLE;
  assign instr_load   = (state_q == S_FETCH) && imem_ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_pass || opcode == OP_NOP) begin
          pc_d    = pc_q + STEP;
          state_d = retire_state;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode == OP_B) begin
          pc_d    = pc_q + immediate_value[PC_W-1:0];
          state_d = retire_state;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WAIT;
      // exec_done is only meaningful here; the strobe cycle itself never completes.
      S_WAIT: begin
        if (exec_done) begin
          if (s_bit) flags_d = alu_flags;
          pc_d    = pc_q + STEP;
          state_d = retire_state;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      flags_q <= '0;
      instr_q <= RESET_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      if (instr_load) instr_q <= imem_data;
    end
  end

  assign imem_req        = (state_q == S_FETCH);
  assign imem_addr       = pc_q;
  assign exec_valid      = (state_q == S_EXEC);
  assign halted          = (state_q == S_HALT);
  assign flags           = flags_q;
  assign pc              = pc_q;
  assign condition       = instr_q[31:28];
  assign opcode          = instr_q[27:24];
  assign s_bit           = instr_q[23];
  assign destination     = instr_q[22:19];
  assign source1         = instr_q[18:15];
  assign source2         = instr_q[14:11];
  assign immediate_value = instr_q[18:3];
  assign shift_control   = instr_q[2:0];

endmodule
